al_commit_scan: RTL and testbench
=================================

// Module: al_commit_scan
// PURPOSE
// - Commit-side reader/clearer of the active-list ready-bit RAM. Owns the AL head pointer and occupancy.
// - Each cycle reads COMMIT_WIDTH ready bits starting at head and commits the longest in-order ready prefix.
// - Clears the committed entries through the RAM commit write ports, then advances head.
// - After reset, sweeps the RAM to zero before declaring itself ready.
// PARAMETERS
// - DEPTH    16  AL entries (power of 2)
// - INDEX    4   log2(DEPTH)
// - CW       4   commit width = RAM read ports = RAM commit write ports (1..4)
// - DW       4   max dispatch pushes per cycle
// PORTS
// - clk           in   1          clock
// - reset         in   1          asynchronous, active-low reset
// - pushCnt_i     in   $clog2(DW+1)  entries dispatched this cycle (tail advance)
// - stall_i       in   1          downstream commit stall; forces k=0
// - flush_i       in   1          squash entire AL
// - rdAddr_o      out  CW*INDEX   RAM read addresses, lane i = head+i mod DEPTH
// - rdData_i      in   CW         ready bit per lane from RAM
// - clrAddr_o     out  CW*INDEX   RAM commit-port write address
// - clrEn_o       out  CW         RAM commit-port write enable (data is always 0)
// - commitVld_o   out  CW         thermometer mask of lanes committing this cycle
// - commitCnt_o   out  $clog2(CW+1)  popcount of commitVld_o
// - headPtr_o     out  INDEX      current head
// - alCount_o     out  INDEX+1    occupancy
// - alFull_o      out  1          alCount_o==DEPTH
// - alEmpty_o     out  1          alCount_o==0
// - ready_o       out  1          init sweep complete
// - overflow_o    out  1          sticky: push exceeded free space
// BEHAVIOUR
// - Reset (async, reset==0): state=INIT, head=0, count=0, sweepPtr=0, overflow_o=0.
//   Outputs while in reset: ready_o=0, commitVld_o=0, clrEn_o=0.
// - States:
//   - INIT: clrEn_o=all 1s, clrAddr_o[i]=sweepPtr+i. sweepPtr+=CW each cycle.
//     - Transition to RUN after ceil(DEPTH/CW) cycles (4 for the defaults).
//     - pushCnt_i, flush_i and stall_i are ignored; commitVld_o=0.
//   - RUN: ready_o=1.
//     - avail = min(count, CW).
//     - k = number of leading 1s in rdData_i[avail-1:0], or 0 if stall_i.
//     - commitVld_o[i] = (i<k); clrEn_o = commitVld_o; clrAddr_o = rdAddr_o.
//     - All of the above are combinational, in the same cycle as the read.
//     - Next edge: head += k (mod DEPTH); count = count + pushCnt_i - k.
//   - There is no other state. A reset mid-sweep or mid-run restarts INIT.
// - Lanes i >= avail are never committed, even if the stale ready bit reads 1.
// - A gap stops commit: rdData_i=4'b1011 gives k=2. Lanes above the gap are not committed.
// - Wrap-around: addresses are computed mod DEPTH (for example, head=14 reads 14,15,0,1).
// - Simultaneous push and commit in one cycle are both applied. A push when full is legal only if k frees enough space.
// - Overflow: if count+pushCnt_i-k > DEPTH, overflow_o is set (sticky until reset) and count saturates at DEPTH.
// - Flush (RUN):
//   - count=0 next edge; head=head+count (head moves to the tail).
//   - In the flush cycle, k=0 and the push is discarded.
//   - Stale set bits are cleared lazily: flush does not sweep them. Lane masking by avail guarantees they are never committed.
//   - Issue-side writes overwrite the bits before reuse.
// CONFIGURATION
// - Optional macro AL_SCAN_PERF_EN. When defined, it adds three outputs (each 32-bit, wrapping, cleared on reset):
//   - stallCyc_o: counts RUN cycles with count>0 and k==0.
//   - commitTot_o: accumulates k.
//   - fullCyc_o: counts cycles with alFull_o=1.
// - When undefined, these ports and counters are absent and core behaviour is identical.
// - Widths follow `COMMIT_WIDTH; CW must equal it.
// STRUCTURE
// - Shared package al_scan_pkg:
//   - typedef enum logic {AL_INIT, AL_RUN} alScanState_t
//   - localparam AL_INIT_CYCLES
//   - head/count typedefs sized from INDEX
// - Sub-module al_lead_ones #(CW): combinational leading-ones count with valid-mask input.
//   It returns k and the thermometer mask.
// - Top module holds the FSM, head, count, sweepPtr, overflow register and the perf counters.
// TESTING
// - Reset, then idle 4 cycles:
//   - clrEn_o=4'hF with addrs 0,4,8,12 on successive cycles.
//   - ready_o rises in cycle 5.
//   - Pushes during INIT are ignored (alCount_o stays 0).
// - count=4, head=0, rdData_i=4'b0111: commitVld_o=4'b0111, commitCnt_o=3, clrAddr_o 0..2, next head=3, count=1.
// - head=14, count=4, rdData_i=4'hF: rdAddr_o=14,15,0,1; next head=2.
// - count=2, rdData_i=4'hF: k=2 only (lanes 2,3 masked).
// - Same counts with stall_i=1: k=0 and clrEn_o=0.
// - count=16, pushCnt_i=2, k=1: overflow_o=1 and count=16.
// - count=16, pushCnt_i=2, k=2: no overflow, count stays 16.
// - flush_i with head=5, count=7, pushCnt_i=3: next head=12, count=0, commitVld_o=0 in the flush cycle.
// - Assert reset mid-RUN: all outputs drop to reset values immediately.
//   After release, a full INIT sweep repeats.
// - With AL_SCAN_PERF_EN: 10 stalled non-empty cycles give stallCyc_o=10; commitTot_o equals the sum of commitCnt_o.

Source files
------------

// File: rtl/al_scan_pkg.sv
// Shared types and sizing for the active-list commit scanner.
// COMMIT_WIDTH sets the default commit width; it falls back to 4 when not defined.
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package al_scan_pkg;

   localparam int AL_DEPTH = 16;
   localparam int AL_INDEX = 4;
   localparam int AL_CW    = `COMMIT_WIDTH;

   typedef enum logic {AL_INIT, AL_RUN} alScanState_t;

   typedef logic [AL_INDEX-1:0] alHead_t;
   typedef logic [AL_INDEX:0]   alCount_t;

   function automatic int al_init_cycles(input int depth, input int cw);
      return (depth + cw - 1) / cw;
   endfunction

   localparam int AL_INIT_CYCLES = al_init_cycles(AL_DEPTH, AL_CW);

endpackage

// File: rtl/al_lead_ones.sv
// Leading-ones counter: counts consecutive set bits from lane 0, only across
// lanes enabled by mask_i, and returns the matching thermometer mask.
module al_lead_ones #(
   parameter int CW = 4
) (
   input  logic [CW-1:0]            data_i,
   input  logic [CW-1:0]            mask_i,
   output logic [$clog2(CW+1)-1:0]  cnt_o,
   output logic [CW-1:0]            therm_o
);

   localparam int KW = $clog2(CW + 1);

   logic chain;

   always_comb begin
      chain   = 1'b1;
      cnt_o   = '0;
      therm_o = '0;
      for (int i = 0; i < CW; i++) begin
         chain      = chain & data_i[i] & mask_i[i];
         therm_o[i] = chain;
         cnt_o      = cnt_o + KW'(chain);
      end
   end

endmodule

// File: rtl/al_commit_scan.sv
// Commit-side scanner of the active-list ready-bit RAM: owns head/occupancy,
// commits the in-order ready prefix each cycle. Optional macro AL_SCAN_PERF_EN adds perf counters.
module al_commit_scan
   import al_scan_pkg::*;
#(
   parameter int DEPTH = AL_DEPTH,
   parameter int INDEX = AL_INDEX,
   parameter int CW    = AL_CW,
   parameter int DW    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [$clog2(DW+1)-1:0]   pushCnt_i,
   input  logic                      stall_i,
   input  logic                      flush_i,
   output logic [CW*INDEX-1:0]       rdAddr_o,
   input  logic [CW-1:0]             rdData_i,
   output logic [CW*INDEX-1:0]       clrAddr_o,
   output logic [CW-1:0]             clrEn_o,
   output logic [CW-1:0]             commitVld_o,
   output logic [$clog2(CW+1)-1:0]   commitCnt_o,
   output logic [INDEX-1:0]          headPtr_o,
   output logic [INDEX:0]            alCount_o,
   output logic                      alFull_o,
   output logic                      alEmpty_o,
   output logic                      ready_o,
   output logic                      overflow_o
`ifdef AL_SCAN_PERF_EN
  ,output logic [31:0]               stallCyc_o,
   output logic [31:0]               commitTot_o,
   output logic [31:0]               fullCyc_o
`endif
);

   localparam int KW       = $clog2(CW + 1);
   localparam int CNT_W    = INDEX + 1;
   localparam int NC_W     = INDEX + 2;
   localparam int INIT_CYC = al_init_cycles(DEPTH, CW);
   localparam int SC_W     = $clog2(INIT_CYC + 1);

   alScanState_t      state;
   logic [INDEX-1:0]  head;
   logic [INDEX-1:0]  sweep_ptr;
   logic [CNT_W-1:0]  count;
   logic [SC_W-1:0]   sweep_cyc;
   logic              overflow;
   logic              run;
   logic [CW-1:0]     lane_ok;
   logic [CW-1:0]     therm;
   logic [KW-1:0]     k;
   logic [NC_W-1:0]   next_count;

   assign run = (state == AL_RUN);

   // Lanes beyond the current occupancy may hold stale ready bits and are never eligible.
   always_comb begin
      lane_ok = '0;
      for (int i = 0; i < CW; i++) begin
         lane_ok[i] = run & ~stall_i & ~flush_i & (count > CNT_W'(i));
      end
   end

   al_lead_ones #(
      .CW(CW)
   ) u_lead_ones (
      .data_i  (rdData_i),
      .mask_i  (lane_ok),
      .cnt_o   (k),
      .therm_o (therm)
   );

   always_comb begin
      rdAddr_o  = '0;
      clrAddr_o = '0;
      for (int i = 0; i < CW; i++) begin
         rdAddr_o[i*INDEX +: INDEX]  = head + INDEX'(i);
         clrAddr_o[i*INDEX +: INDEX] = run ? (head + INDEX'(i)) : (sweep_ptr + INDEX'(i));
      end
   end

   // The sweep enable is gated by reset so the RAM is not written while reset is held.
   assign clrEn_o     = run ? therm : {CW{reset}};
   assign commitVld_o = therm;
   assign commitCnt_o = k;
   assign next_count  = NC_W'(count) + NC_W'(pushCnt_i) - NC_W'(k);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= AL_INIT;
         head      <= '0;
         count     <= '0;
         sweep_ptr <= '0;
         sweep_cyc <= '0;
         overflow  <= 1'b0;
      end else if (!run) begin
         sweep_ptr <= sweep_ptr + INDEX'(CW);
         sweep_cyc <= sweep_cyc + SC_W'(1);
         if (sweep_cyc == SC_W'(INIT_CYC - 1)) begin
            state <= AL_RUN;
         end
      end else if (flush_i) begin
         head  <= head + INDEX'(count);
         count <= '0;
      end else begin
         head <= head + INDEX'(k);
         if (next_count > NC_W'(DEPTH)) begin
            overflow <= 1'b1;
            count    <= CNT_W'(DEPTH);
         end else begin
            count <= next_count[CNT_W-1:0];
         end
      end
   end

   assign headPtr_o  = head;
   assign alCount_o  = count;
   assign alFull_o   = (count == CNT_W'(DEPTH));
   assign alEmpty_o  = (count == '0);
   assign ready_o    = run;
   assign overflow_o = overflow;

`ifdef AL_SCAN_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stallCyc_o  <= '0;
         commitTot_o <= '0;
         fullCyc_o   <= '0;
      end else begin
         if (run && (count != '0) && (k == '0)) begin
            stallCyc_o <= stallCyc_o + 32'd1;
         end
         commitTot_o <= commitTot_o + 32'(k);
         if (alFull_o) begin
            fullCyc_o <= fullCyc_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_al_commit_scan.sv
// Randomized + directed bench for al_commit_scan against a behavioural occupancy model.
module tb_al_commit_scan;

   localparam int DEPTH = 16;
   localparam int CW    = 4;
   localparam int INIT_CYC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  pushCnt_i = '0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [15:0] rdAddr_o;
   logic [3:0]  rdData_i = '0;
   logic [15:0] clrAddr_o;
   logic [3:0]  clrEn_o;
   logic [3:0]  commitVld_o;
   logic [2:0]  commitCnt_o;
   logic [3:0]  headPtr_o;
   logic [4:0]  alCount_o;
   logic        alFull_o, alEmpty_o, ready_o, overflow_o;
`ifdef AL_SCAN_PERF_EN
   logic [31:0] stallCyc_o, commitTot_o, fullCyc_o;
`endif

   always #5 clk = ~clk;

   al_commit_scan dut (
      .clk         (clk),
      .reset       (reset),
      .pushCnt_i   (pushCnt_i),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .rdAddr_o    (rdAddr_o),
      .rdData_i    (rdData_i),
      .clrAddr_o   (clrAddr_o),
      .clrEn_o     (clrEn_o),
      .commitVld_o (commitVld_o),
      .commitCnt_o (commitCnt_o),
      .headPtr_o   (headPtr_o),
      .alCount_o   (alCount_o),
      .alFull_o    (alFull_o),
      .alEmpty_o   (alEmpty_o),
      .ready_o     (ready_o),
      .overflow_o  (overflow_o)
`ifdef AL_SCAN_PERF_EN
     ,.stallCyc_o  (stallCyc_o),
      .commitTot_o (commitTot_o),
      .fullCyc_o   (fullCyc_o)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit m_run;
   int m_sweep, m_head, m_count;
   bit m_ovf;
   int p_stall, p_tot, p_full;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_sweep = 0; m_head = 0; m_count = 0; m_ovf = 0;
      p_stall = 0; p_tot = 0; p_full = 0;
   endtask

   function automatic int model_k();
      int avail, kk;
      if (!reset || !m_run || stall_i || flush_i) return 0;
      avail = (m_count < CW) ? m_count : CW;
      kk = 0;
      while (kk < avail && rdData_i[kk]) kk++;
      return kk;
   endfunction

   task automatic check_outputs();
      int kk;
      logic [3:0]  e_vld, e_en;
      logic [15:0] e_rd, e_clr;
      kk = model_k();
      e_vld = 4'((1 << kk) - 1);
      for (int i = 0; i < CW; i++) begin
         e_rd[i*4 +: 4]  = 4'((m_head + i) % DEPTH);
         e_clr[i*4 +: 4] = m_run ? 4'((m_head + i) % DEPTH) : 4'((m_sweep * CW + i) % DEPTH);
      end
      e_en = !reset ? 4'h0 : (m_run ? e_vld : 4'hF);
      chk("ready",    ready_o,     m_run);
      chk("vld",      commitVld_o, e_vld);
      chk("cnt",      commitCnt_o, kk);
      chk("clr_en",   clrEn_o,     e_en);
      chk("rd_addr",  rdAddr_o,    e_rd);
      chk("clr_addr", clrAddr_o,   e_clr);
      chk("head",     headPtr_o,   m_head);
      chk("count",    alCount_o,   m_count);
      chk("full",     alFull_o,    m_count == DEPTH);
      chk("empty",    alEmpty_o,   m_count == 0);
      chk("ovf",      overflow_o,  m_ovf);
`ifdef AL_SCAN_PERF_EN
      chk("p_stall",  stallCyc_o,  p_stall);
      chk("p_tot",    commitTot_o, p_tot);
      chk("p_full",   fullCyc_o,   p_full);
`endif
   endtask

   task automatic model_update();
      int kk, nc;
      if (!reset) return;
      kk = model_k();
      if (m_run && m_count > 0 && kk == 0) p_stall++;
      p_tot += kk;
      if (m_count == DEPTH) p_full++;
      if (!m_run) begin
         m_sweep++;
         if (m_sweep == INIT_CYC) m_run = 1;
      end else if (flush_i) begin
         m_head  = (m_head + m_count) % DEPTH;
         m_count = 0;
      end else begin
         m_head = (m_head + kk) % DEPTH;
         nc = m_count + int'(pushCnt_i) - kk;
         if (nc > DEPTH) begin
            m_ovf = 1;
            nc = DEPTH;
         end
         m_count = nc;
      end
   endtask

   task automatic set(input int push, input bit st, input bit fl, input logic [3:0] rd);
      pushCnt_i = 3'(push); stall_i = st; flush_i = fl; rdData_i = rd;
   endtask

   // inputs change at posedge+1, checks at posedge+4..6, then the edge
   task automatic cyc();
      #3;
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_and_sweep();
      logic [15:0] e;
      reset = 1'b0;
      model_reset();
      set(0, 0, 0, 4'h0);
      cyc();
      cyc();
      reset = 1'b1;
      for (int c = 0; c < INIT_CYC; c++) begin
         set(4, 0, 1, 4'hF);
         for (int i = 0; i < CW; i++) e[i*4 +: 4] = 4'(c * CW + i);
         #2;
         chk("init_en", clrEn_o, 4'hF);
         chk("init_addr", clrAddr_o, e);
         chk("init_rdy", ready_o, 1'b0);
         cyc();
      end
      chk("init_cnt", alCount_o, 5'd0);
      chk("init_done", ready_o, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      reset_and_sweep();

      // prefix commit from head 0
      set(4, 1, 0, 4'h0); cyc();
      set(0, 0, 0, 4'b0111); #2;
      chk("d1_vld", commitVld_o, 4'b0111);
      chk("d1_cnt", commitCnt_o, 3'd3);
      chk("d1_clr", clrAddr_o[11:0], 12'h210);
      cyc();
      chk("d1_head", headPtr_o, 4'd3);
      chk("d1_count", alCount_o, 5'd1);

      // wrap-around at head 14
      set(4, 1, 0, 4'h0); cyc();
      set(4, 1, 0, 4'h0); cyc();
      set(2, 1, 0, 4'h0); cyc();
      set(0, 0, 1, 4'hF); cyc();
      chk("d2_flush_head", headPtr_o, 4'd14);
      set(4, 1, 0, 4'h0); cyc();
      set(0, 0, 0, 4'hF); #2;
      chk("d2_rdaddr", rdAddr_o, 16'h10FE);
      cyc();
      chk("d2_head", headPtr_o, 4'd2);

      // avail masking and stall
      set(2, 1, 0, 4'h0); cyc();
      set(0, 1, 0, 4'hF); #2;
      chk("d3_stall_vld", commitVld_o, 4'h0);
      chk("d3_stall_en", clrEn_o, 4'h0);
      cyc();
      set(0, 0, 0, 4'hF); #2;
      chk("d3_mask_vld", commitVld_o, 4'b0011);
      chk("d3_mask_cnt", commitCnt_o, 3'd2);
      cyc();

      // gap stops commit
      set(4, 1, 0, 4'h0); cyc();
      set(0, 0, 0, 4'b1011); #2;
      chk("d4_gap_vld", commitVld_o, 4'b0011);
      cyc();
      set(0, 0, 0, 4'hF); cyc();

      // full, push with enough commit, then overflow
      for (int i = 0; i < 4; i++) begin set(4, 1, 0, 4'h0); cyc(); end
      chk("d5_full", alFull_o, 1'b1);
      set(2, 0, 0, 4'b0011); cyc();
      chk("d5_noovf", overflow_o, 1'b0);
      chk("d5_cnt16", alCount_o, 5'd16);
      set(2, 0, 0, 4'b0001); cyc();
      chk("d5_ovf", overflow_o, 1'b1);
      chk("d5_sat", alCount_o, 5'd16);

      // async reset mid-run
      reset = 1'b0;
      #1;
      chk("rst_rdy", ready_o, 1'b0);
      chk("rst_vld", commitVld_o, 4'h0);
      chk("rst_en", clrEn_o, 4'h0);
      chk("rst_cnt", alCount_o, 5'd0);
      chk("rst_ovf", overflow_o, 1'b0);
      @(posedge clk); #1;
      reset_and_sweep();

      // flush from head 5, count 7, with a discarded push
      set(4, 1, 0, 4'h0); cyc();
      set(2, 1, 0, 4'h0); cyc();
      set(0, 0, 0, 4'hF); cyc();
      set(0, 0, 0, 4'b0001); cyc();
      set(4, 1, 0, 4'h0); cyc();
      set(2, 1, 0, 4'h0); cyc();
      chk("d6_pre_head", headPtr_o, 4'd5);
      chk("d6_pre_cnt", alCount_o, 5'd7);
      set(3, 0, 1, 4'hF); #2;
      chk("d6_flush_vld", commitVld_o, 4'h0);
      cyc();
      chk("d6_head", headPtr_o, 4'd12);
      chk("d6_count", alCount_o, 5'd0);

      // stalled non-empty cycles after a fresh reset
      reset_and_sweep();
      set(4, 1, 0, 4'h0); cyc();
      for (int i = 0; i < 10; i++) begin set(0, 1, 0, 4'hF); cyc(); end
`ifdef AL_SCAN_PERF_EN
      chk("perf_stall10", stallCyc_o, 32'd10);
`endif

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         if (n == 300) reset_and_sweep();
         set(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 24) == 0), 4'($urandom));
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
